// File: rtl/read_info.sv
// Read-request tracker: queues read descriptors and steers returned data words to the stream or buffer sink.
// Latency: a queued descriptor becomes active 1 cycle after it reaches the FIFO head; each word pops in the cycle it is offered.
// Backpressure: rd_req is dropped while read_info_full=1; inbuf_pop is held low while the selected sink is full.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   read_info_full        descriptor FIFO holds INFO_DEPTH entries
//   rd_req, rd_req_*      push one {size, pu_id, d_type} descriptor
//   inbuf_empty/inbuf_pop returned-data input buffer handshake
//   stream_full/_push     stream sink status and write strobe (d_type == 0)
//   buffer_full/_push     buffer sink status and write strobe (d_type != 0)
//   pu_id, d_type         routing fields of the active transaction

// Generic synchronous FIFO with registered occupancy count.
// Latency: a pushed entry is visible at pop_dat on the next cycle.
// Backpressure: push is ignored while full, pop is ignored while empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers are AW bits wide, so DEPTH being a power of two makes
    // the increment wrap exactly at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module read_info #(
    parameter int   NUM_PU     = 1,
    parameter int   D_TYPE_W   = 2,
    parameter int   RD_SIZE_W  = 20,
    parameter int   INFO_DEPTH = 4,
    localparam int  PU_ID_W    = $clog2(NUM_PU) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 read_info_full,
    input  logic                 rd_req,
    input  logic [RD_SIZE_W-1:0] rd_req_size,
    input  logic [PU_ID_W-1:0]   rd_req_pu_id,
    input  logic [D_TYPE_W-1:0]  rd_req_d_type,
    input  logic                 inbuf_empty,
    output logic                 inbuf_pop,
    input  logic                 stream_full,
    input  logic                 buffer_full,
    output logic                 stream_push,
    output logic                 buffer_push,
    output logic [PU_ID_W-1:0]   pu_id,
    output logic [D_TYPE_W-1:0]  d_type
);
    typedef struct packed {
        logic [RD_SIZE_W-1:0] size;
        logic [PU_ID_W-1:0]   pu_id;
        logic [D_TYPE_W-1:0]  d_type;
    } info_t;

    info_t                req_dat;
    info_t                head_dat;
    logic                 info_empty;
    logic                 info_pop;
    logic                 active;
    logic [RD_SIZE_W-1:0] remaining;
    logic                 is_stream;
    logic                 dest_full;

    assign req_dat.size   = rd_req_size;
    assign req_dat.pu_id  = rd_req_pu_id;
    assign req_dat.d_type = rd_req_d_type;

    fifo #(
        .W     ($bits(info_t)),
        .DEPTH (INFO_DEPTH)
    ) u_info_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_req),
        .push_dat (req_dat),
        .pop      (info_pop),
        .pop_dat  (head_dat),
        .full     (read_info_full),
        .empty    (info_empty)
    );

    // Only one descriptor is in flight; the next one is fetched in the
    // cycle after the last word of the current one has been popped.
    assign info_pop = ~active & ~info_empty;

    // d_type 0 routes to the stream sink, every other type to the buffer.
    assign is_stream   = (d_type == '0);
    assign dest_full   = is_stream ? stream_full : buffer_full;
    assign inbuf_pop   = active & ~inbuf_empty & ~dest_full;
    assign stream_push = inbuf_pop & is_stream;
    assign buffer_push = inbuf_pop & ~is_stream;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active    <= 1'b0;
            remaining <= '0;
            pu_id     <= '0;
            d_type    <= '0;
        end else if (info_pop) begin
            // A zero-size descriptor completes on load: routing fields
            // update but no word is ever requested from the input buffer.
            active    <= (head_dat.size != '0);
            remaining <= head_dat.size;
            pu_id     <= head_dat.pu_id;
            d_type    <= head_dat.d_type;
        end else if (inbuf_pop) begin
            remaining <= remaining - RD_SIZE_W'(1);
            if (remaining == RD_SIZE_W'(1)) begin
                active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_read_info.sv
module tb_read_info;
    localparam int RSW   = 6;
    localparam int DTW   = 2;
    localparam int PUW   = 1;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           read_info_full;
    logic           rd_req;
    logic [RSW-1:0] rd_req_size;
    logic [PUW-1:0] rd_req_pu_id;
    logic [DTW-1:0] rd_req_d_type;
    logic           inbuf_empty;
    logic           inbuf_pop;
    logic           stream_full;
    logic           buffer_full;
    logic           stream_push;
    logic           buffer_push;
    logic [PUW-1:0] pu_id;
    logic [DTW-1:0] d_type;

    read_info #(
        .NUM_PU     (1),
        .D_TYPE_W   (DTW),
        .RD_SIZE_W  (RSW),
        .INFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .read_info_full (read_info_full),
        .rd_req         (rd_req),
        .rd_req_size    (rd_req_size),
        .rd_req_pu_id   (rd_req_pu_id),
        .rd_req_d_type  (rd_req_d_type),
        .inbuf_empty    (inbuf_empty),
        .inbuf_pop      (inbuf_pop),
        .stream_full    (stream_full),
        .buffer_full    (buffer_full),
        .stream_push    (stream_push),
        .buffer_push    (buffer_push),
        .pu_id          (pu_id),
        .d_type         (d_type)
    );

    always #5 clk = ~clk;

    // One scoreboard entry per data word the DUT is expected to pop.
    typedef struct packed {
        logic [PUW-1:0] pu;
        logic [DTW-1:0] dt;
        logic           strm;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   pop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_req(input int sz, input int pu, input int dt);
        rd_req_size   = RSW'(sz);
        rd_req_pu_id  = PUW'(pu);
        rd_req_d_type = DTW'(dt);
    endtask

    task automatic expect_words(input int n, input int pu, input int dt);
        exp_t e;
        e.pu   = PUW'(pu);
        e.dt   = DTW'(dt);
        e.strm = (dt == 0);
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(sb_q.size()), 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every popped word is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (inbuf_pop) begin
            pop_cnt++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pop: got pop pu_id=%0d d_type=%0d, required no pop (t=%0t)",
                         pu_id, d_type, $time);
            end else begin
                e = sb_q.pop_front();
                check("mon_pu_id", 32'(pu_id), 32'(e.pu));
                check("mon_d_type", 32'(d_type), 32'(e.dt));
                check("mon_stream_push", 32'(stream_push), 32'(e.strm));
                check("mon_buffer_push", 32'(buffer_push), 32'(!e.strm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int sz_t [5] = '{2, 1, 1, 2, 3};
        int pu_t [5] = '{1, 0, 1, 0, 1};
        int dt_t [5] = '{0, 1, 3, 0, 1};

        reset = 1'b1; rd_req = 1'b0; set_req(0, 0, 0);
        inbuf_empty = 1'b1; stream_full = 1'b0; buffer_full = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_full", 32'(read_info_full), 0);
        check("rst_inbuf_pop", 32'(inbuf_pop), 0);
        check("rst_stream_push", 32'(stream_push), 0);
        check("rst_buffer_push", 32'(buffer_push), 0);
        check("rst_pu_id", 32'(pu_id), 0);
        check("rst_d_type", 32'(d_type), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single stream request: words in cycles 2..4 after rd_req.
        inbuf_empty = 1'b0;
        set_req(3, 0, 0);
        expect_words(3, 0, 0);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rd_req = (c == 0);
            @(negedge clk);
            check("t1_stream_push", 32'(stream_push), (c >= 2 && c <= 4) ? 1 : 0);
            check("t1_buffer_push", 32'(buffer_push), 0);
        end
        drain("t1_drain", 20);

        // Buffer request with a 2-cycle sink stall; stream_full must not matter.
        stream_full = 1'b1;
        set_req(4, 1, 1);
        expect_words(4, 1, 1);
        p0 = pop_cnt;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            rd_req      = (c == 0);
            buffer_full = (c == 4 || c == 5);
            @(negedge clk);
            if (c == 4 || c == 5) begin
                check("t2_stall_inbuf_pop", 32'(inbuf_pop), 0);
                check("t2_stall_buffer_push", 32'(buffer_push), 0);
            end
            if (c == 6) check("t2_resume_buffer_push", 32'(buffer_push), 1);
        end
        check("t2_total_pops", 32'(pop_cnt - p0), 4);
        stream_full = 1'b0;
        drain("t2_drain", 20);

        // Full FIFO: a stalled request first occupies the active slot, so the
        // following burst fills all 4 FIFO entries and its 5th request is dropped.
        inbuf_empty = 1'b1;
        set_req(1, 0, 2);
        expect_words(1, 0, 2);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rd_req = (c == 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            rd_req = 1'b1;
            set_req(sz_t[k], pu_t[k], dt_t[k]);
            if (k < 4) expect_words(sz_t[k], pu_t[k], dt_t[k]);
            @(negedge clk);
            check("t3_full", 32'(read_info_full), (k == 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        check("t3_full_after_drop", 32'(read_info_full), 1);
        inbuf_empty = 1'b0;
        drain("t3_drain", 100);
        check("t3_full_cleared", 32'(read_info_full), 0);

        // Back-to-back stream then buffer: routing switches only after word 2.
        set_req(2, 0, 0);
        expect_words(2, 0, 0);
        expect_words(1, 1, 2);
        p0 = pop_cnt;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            rd_req = (c <= 1);
            if (c == 1) set_req(1, 1, 2);
            @(negedge clk);
            if (c == 4) begin
                check("t4_gap_inbuf_pop", 32'(inbuf_pop), 0);
                check("t4_gap_d_type", 32'(d_type), 0);
                check("t4_gap_pu_id", 32'(pu_id), 0);
            end
            if (c == 5) begin
                check("t4_buffer_push", 32'(buffer_push), 1);
                check("t4_new_d_type", 32'(d_type), 2);
                check("t4_new_pu_id", 32'(pu_id), 1);
            end
            if (c == 6) begin
                check("t4_idle_buffer_push", 32'(buffer_push), 0);
                check("t4_idle_d_type", 32'(d_type), 2);
            end
        end
        check("t4_total_pops", 32'(pop_cnt - p0), 3);
        drain("t4_drain", 20);

        // Zero-size request followed by a 1-word request.
        set_req(0, 1, 1);
        p0 = pop_cnt;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rd_req = (c <= 1);
            if (c == 1) begin
                set_req(1, 0, 0);
                expect_words(1, 0, 0);
            end
            @(negedge clk);
            if (c == 2) check("t5_no_pop_for_size0", 32'(inbuf_pop), 0);
            if (c == 3) check("t5_stream_push", 32'(stream_push), 1);
        end
        check("t5_total_pops", 32'(pop_cnt - p0), 1);
        drain("t5_drain", 20);

        // Largest size field value transfers exactly 2^RSW-1 words.
        set_req(63, 1, 3);
        expect_words(63, 1, 3);
        p0 = pop_cnt;
        @(posedge clk); #1; rd_req = 1'b1;
        @(posedge clk); #1; rd_req = 1'b0;
        drain("tmax_drain", 200);
        repeat (5) @(posedge clk);
        check("tmax_total_pops", 32'(pop_cnt - p0), 63);

        // Reset after the first of 3 words, with a second request queued.
        p0 = pop_cnt;
        set_req(3, 1, 0);
        expect_words(1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rd_req = (c <= 1);
            if (c == 1) set_req(2, 0, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t6_rst_inbuf_pop", 32'(inbuf_pop), 0);
        check("t6_rst_stream_push", 32'(stream_push), 0);
        check("t6_rst_buffer_push", 32'(buffer_push), 0);
        check("t6_rst_full", 32'(read_info_full), 0);
        check("t6_rst_pu_id", 32'(pu_id), 0);
        check("t6_rst_d_type", 32'(d_type), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_pops_total", 32'(pop_cnt - p0), 1);
        check("t6_sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
